// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step per cycle,
// XLEN iterations per operation, registered busy/done/result for the EX stage.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   operand_q, operand_d;
  logic [XLEN-1:0]   a_raw_q, a_raw_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              neg_q, neg_d;
  logic              div_zero_q, div_zero_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_part;
  logic [XLEN-1:0]   div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] step;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot_s, rem_s;
  logic [XLEN-1:0]   final_val;

  // Accept-time operand conditioning: magnitudes plus the sign the final value must carry.
  always_comb begin
    a_neg = (funct3 inside {F_MULH, F_MULHSU, F_DIV, F_REM}) && op_a[XLEN-1];
    b_neg = (funct3 inside {F_MULH, F_DIV, F_REM}) && op_b[XLEN-1];
    a_mag = a_neg ? -op_a : op_a;
    b_mag = b_neg ? -op_b : op_b;
  end

  // One iteration. Multiply: acc = {partial_hi, multiplier}, shifted right each step.
  // Divide: acc = {remainder, dividend->quotient}, shifted left each step.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, operand_q} : '0);
    div_part = acc_q[2*XLEN-1:XLEN-1];
    div_ge   = div_part >= {1'b0, operand_q};
    div_diff = div_part[XLEN-1:0] - operand_q;
    if (funct3_q[2]) begin
      step = {(div_ge ? div_diff : div_part[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
    end else begin
      step = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  always_comb begin
    prod   = neg_q ? -step : step;
    quot_s = neg_q ? -step[XLEN-1:0] : step[XLEN-1:0];
    rem_s  = neg_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
    case (funct3_q)
      F_MUL:                     final_val = prod[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU: final_val = prod[2*XLEN-1:XLEN];
      F_DIV:                     final_val = div_zero_q ? '1 : (ovf_q ? a_raw_q : quot_s);
      F_DIVU:                    final_val = div_zero_q ? '1 : quot_s;
      F_REM:                     final_val = div_zero_q ? a_raw_q : (ovf_q ? '0 : rem_s);
      F_REMU:                    final_val = div_zero_q ? a_raw_q : rem_s;
      default:                   final_val = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    acc_d      = acc_q;
    operand_d  = operand_q;
    a_raw_d    = a_raw_q;
    result_d   = result_q;
    funct3_d   = funct3_q;
    neg_d      = neg_q;
    div_zero_d = div_zero_q;
    ovf_d      = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d    = RUN;
          count_d    = '0;
          funct3_d   = funct3;
          // Remainder takes the dividend's sign; everything else takes the product/quotient sign.
          neg_d      = (funct3 == F_REM) ? a_neg : (a_neg ^ b_neg);
          acc_d      = {{XLEN{1'b0}}, (funct3[2] ? a_mag : b_mag)};
          operand_d  = funct3[2] ? b_mag : a_mag;
          a_raw_d    = op_a;
          div_zero_d = (op_b == '0);
          ovf_d      = (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
        end
      end
      RUN: begin
        acc_d   = step;
        count_d = count_q + 1'b1;
        if (count_q == CW'(XLEN-1)) begin
          state_d  = DONE;
          result_d = final_val;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d  = IDLE;
      count_d  = '0;
      result_d = result_q;
    end

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      acc_q      <= '0;
      operand_q  <= '0;
      a_raw_q    <= '0;
      result_q   <= '0;
      funct3_q   <= '0;
      neg_q      <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      operand_q  <= operand_d;
      a_raw_q    <= a_raw_d;
      result_q   <= result_d;
      funct3_q   <= funct3_d;
      neg_q      <= neg_d;
      div_zero_q <= div_zero_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
